systolic_wavefront_feeder: RTL and testbench

Parametrised west-edge feeder for the systolic array. It reads an M×M operand matrix (runtime M ≤ LANES) from the operand buffer through a single read port with 1-cycle latency and assembles 2M−1 skewed diagonal wavefronts. Each wavefront is presented on LANES west ports under a valid/ready handshake. It adds runtime sizing, output backpressure, start/done control, a configuration error flag and address wrap-around.

---
 rtl/systolic_feeder_pkg.sv | 32 +++
 rtl/wavefront_addr_gen.sv | 90 +++++++++
 rtl/systolic_wavefront_feeder.sv | 188 ++++++++++++++++++
 tb/tb_systolic_wavefront_feeder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_feeder_pkg.sv
// systolic_feeder_pkg
// Shared types and helpers for the systolic west-edge feeder.
//   feeder_state_e   : control FSM states (idle / issuing reads / draining last wavefront)
//   lane_tag_t       : lane index carried alongside each outstanding buffer read
//   wf_bounds_t      : first/last active lane of one skewed wavefront
//   wavefront_bounds : active lane range of wavefront k for an M x M operand
package systolic_feeder_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } feeder_state_e;

  localparam int unsigned LaneTagWidth = 8;

  typedef logic [LaneTagWidth-1:0] lane_tag_t;

  typedef struct packed {
    lane_tag_t first;
    lane_tag_t last;
  } wf_bounds_t;

  // Wavefront k covers lanes i with 0 <= k-i < m, i.e. max(0, k-m+1) .. min(k, m-1).
  function automatic wf_bounds_t wavefront_bounds(input int unsigned k, input int unsigned m);
    wf_bounds_t b;
    b.first = (k >= m) ? lane_tag_t'(k - m + 1) : '0;
    b.last  = (k < m) ? lane_tag_t'(k) : lane_tag_t'(m - 1);
    return b;
  endfunction

endpackage

// File: rtl/wavefront_addr_gen.sv
// wavefront_addr_gen
// Walks the skewed wavefront schedule of an M x M operand and produces one buffer
// address per active lane, ascending lane order within each wavefront.
// Ports:
//   clk, rst_flush   : clock, synchronous active-high reset
//   i_load           : latch base / M / transpose and restart at wavefront 0, lane 0
//   i_base, i_m      : address of element (0,0) and runtime matrix size
//   i_transpose      : 1 = column-major addressing (base + c*M + r)
//   i_advance        : the current address was issued this cycle
//   o_addr, o_lane   : address and lane of the current element
//   o_last_elem      : current element is the last of its wavefront
//   o_final          : current element is the last read of the whole matrix
module wavefront_addr_gen
  import systolic_feeder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LANES      = 8
) (
  input  logic                        clk,
  input  logic                        rst_flush,
  input  logic                        i_load,
  input  logic [ADDR_WIDTH-1:0]       i_base,
  input  logic [$clog2(LANES):0]      i_m,
  input  logic                        i_transpose,
  input  logic                        i_advance,
  output logic [ADDR_WIDTH-1:0]       o_addr,
  output lane_tag_t                   o_lane,
  output logic                        o_last_elem,
  output logic                        o_final
);

  localparam int unsigned MW = $clog2(LANES) + 1;
  localparam int unsigned KW = $clog2(2 * LANES);

  logic [ADDR_WIDTH-1:0] r_base;
  logic [MW-1:0]         r_m;
  logic                  r_transpose;
  logic [KW-1:0]         r_k;
  lane_tag_t             r_lane;

  wf_bounds_t            w_cur;
  wf_bounds_t            w_nxt;
  logic [ADDR_WIDTH-1:0] w_row;
  logic [ADDR_WIDTH-1:0] w_col;
  logic [ADDR_WIDTH-1:0] w_mw;
  logic                  w_unused_bounds;

  always_comb begin
    w_cur = wavefront_bounds(32'(r_k), 32'(r_m));
    w_nxt = wavefront_bounds(32'(r_k) + 32'd1, 32'(r_m));
  end

  assign w_unused_bounds = ^{w_cur.first, w_nxt.last};

  // Row/column of the current element; arithmetic is modulo 2^ADDR_WIDTH so the
  // address wraps silently past the top of the buffer.
  assign w_row = ADDR_WIDTH'(r_lane);
  assign w_col = ADDR_WIDTH'(r_k) - w_row;
  assign w_mw  = ADDR_WIDTH'(r_m);

  assign o_addr      = r_transpose ? (r_base + w_col * w_mw + w_row)
                                   : (r_base + w_row * w_mw + w_col);
  assign o_lane      = r_lane;
  assign o_last_elem = (r_lane == w_cur.last);
  assign o_final     = o_last_elem && ((32'(r_k) + 32'd2) == (32'(r_m) << 1));

  always_ff @(posedge clk) begin
    if (rst_flush) begin
      r_base      <= '0;
      r_m         <= '0;
      r_transpose <= 1'b0;
      r_k         <= '0;
      r_lane      <= '0;
    end else if (i_load) begin
      r_base      <= i_base;
      r_m         <= i_m;
      r_transpose <= i_transpose;
      r_k         <= '0;
      r_lane      <= '0;
    end else if (i_advance) begin
      if (o_last_elem) begin
        r_k    <= r_k + KW'(1);
        r_lane <= w_nxt.first;
      end else begin
        r_lane <= r_lane + lane_tag_t'(1);
      end
    end
  end

endmodule

// File: rtl/systolic_wavefront_feeder.sv
// systolic_wavefront_feeder
// West-edge feeder: reads an M x M operand (1 <= M <= LANES) through a 1-cycle-latency
// read port and presents 2M-1 skewed diagonal wavefronts on LANES west ports under
// valid/ready. Wavefront k, lane i carries A[i][k-i] when 0 <= k-i < M, else 0.
// Optional feature macro: FEEDER_TRANSPOSE_EN adds transpose_in (column-major addressing).
// Ports:
//   clk, rst_flush        : clock, synchronous active-high reset / flush
//   start                 : launch, sampled only when idle
//   base_addr_in          : address of element (0,0), sampled at start
//   matrix_width_in       : M, sampled at start; 0 or > LANES is rejected (cfg_err)
//   transpose_in          : (FEEDER_TRANSPOSE_EN only) column-major select, sampled at start
//   rd_en, rd_addr        : buffer read strobe / address
//   rd_data               : read data, valid the cycle after rd_en
//   west_ports, out_valid : wavefront output, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_ready             : array accepts the presented wavefront
//   busy                  : not idle
//   done                  : one-cycle pulse when the final wavefront is accepted
//   cfg_err               : one-cycle pulse on a rejected start
module systolic_wavefront_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LANES      = 8
) (
  input  logic                        clk,
  input  logic                        rst_flush,
  input  logic                        start,
  input  logic [ADDR_WIDTH-1:0]       base_addr_in,
  input  logic [$clog2(LANES):0]      matrix_width_in,
`ifdef FEEDER_TRANSPOSE_EN
  input  logic                        transpose_in,
`endif
  output logic                        rd_en,
  output logic [ADDR_WIDTH-1:0]       rd_addr,
  input  logic [DATA_WIDTH-1:0]       rd_data,
  output logic [LANES*DATA_WIDTH-1:0] west_ports,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy,
  output logic                        done,
  output logic                        cfg_err
);

  feeder_state_e                     r_state;
  logic                              r_pipe_valid;
  logic                              r_pipe_last;
  lane_tag_t                         r_pipe_lane;
  logic [LANES-1:0][DATA_WIDTH-1:0]  r_shadow;
  logic                              r_shadow_full;
  logic [LANES-1:0][DATA_WIDTH-1:0]  r_west;
  logic                              r_out_valid;
  logic                              r_done;
  logic                              r_cfg_err;

  logic                              w_transpose;
  logic                              w_m_ok;
  logic                              w_load;
  logic                              w_stall;
  logic                              w_issue;
  logic                              w_accept;
  logic                              w_out_free;
  logic [ADDR_WIDTH-1:0]             w_addr;
  lane_tag_t                         w_lane;
  logic                              w_last_elem;
  logic                              w_final;
  logic [LANES-1:0][DATA_WIDTH-1:0]  w_merged;

`ifdef FEEDER_TRANSPOSE_EN
  assign w_transpose = transpose_in;
`else
  assign w_transpose = 1'b0;
`endif

  assign w_m_ok     = (matrix_width_in != '0) && (32'(matrix_width_in) <= LANES);
  assign w_load     = (r_state == StIdle) && start && w_m_ok;
  // Hold issue while a wavefront's closing read is outstanding (gives the one-cycle
  // bubble) and while a completed wavefront is parked in the shadow.
  assign w_stall    = (r_pipe_valid && r_pipe_last) || r_shadow_full;
  assign w_issue    = (r_state == StRun) && !w_stall;
  assign w_accept   = r_out_valid && out_ready;
  assign w_out_free = !r_out_valid || out_ready;

  wavefront_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LANES      (LANES)
  ) u_addr_gen (
    .clk         (clk),
    .rst_flush   (rst_flush),
    .i_load      (w_load),
    .i_base      (base_addr_in),
    .i_m         (matrix_width_in),
    .i_transpose (w_transpose),
    .i_advance   (w_issue),
    .o_addr      (w_addr),
    .o_lane      (w_lane),
    .o_last_elem (w_last_elem),
    .o_final     (w_final)
  );

  // Shadow with the returning element dropped into its tagged lane.
  always_comb begin
    w_merged = r_shadow;
    for (int i = 0; i < int'(LANES); i++) begin
      if (r_pipe_lane == lane_tag_t'(i)) begin
        w_merged[i] = rd_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_flush) begin
      r_state       <= StIdle;
      r_pipe_valid  <= 1'b0;
      r_pipe_last   <= 1'b0;
      r_pipe_lane   <= '0;
      r_shadow      <= '0;
      r_shadow_full <= 1'b0;
      r_west        <= '0;
      r_out_valid   <= 1'b0;
      r_done        <= 1'b0;
      r_cfg_err     <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;

      r_pipe_valid <= w_issue;
      r_pipe_last  <= w_issue && w_last_elem;
      r_pipe_lane  <= w_lane;

      if (w_accept) begin
        r_out_valid <= 1'b0;
      end

      if (r_pipe_valid) begin
        if (r_pipe_last && w_out_free) begin
          r_west      <= w_merged;
          r_out_valid <= 1'b1;
          r_shadow    <= '0;
        end else begin
          r_shadow <= w_merged;
          if (r_pipe_last) begin
            r_shadow_full <= 1'b1;
          end
        end
      end else if (r_shadow_full && w_out_free) begin
        r_west        <= r_shadow;
        r_out_valid   <= 1'b1;
        r_shadow      <= '0;
        r_shadow_full <= 1'b0;
      end

      unique case (r_state)
        StIdle: begin
          if (start) begin
            if (w_m_ok) begin
              r_state <= StRun;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
        end
        StRun: begin
          if (w_issue && w_final) begin
            r_state <= StDrain;
          end
        end
        StDrain: begin
          // Nothing in flight or parked: the presented wavefront is the final one.
          if (!r_pipe_valid && !r_shadow_full && w_accept) begin
            r_state <= StIdle;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign rd_en      = w_issue;
  assign rd_addr    = w_issue ? w_addr : '0;
  assign west_ports = r_west;
  assign out_valid  = r_out_valid;
  assign busy       = (r_state != StIdle);
  assign done       = r_done;
  assign cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_systolic_wavefront_feeder.sv
// Self-checking bench for systolic_wavefront_feeder (LANES=4, row-major build).
module tb_systolic_wavefront_feeder;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 8;
  localparam int unsigned LANES = 4;
  localparam int unsigned MW    = 3;
  localparam int unsigned WW    = LANES * DW;

  logic          clk = 1'b0;
  logic          rst_flush;
  logic          start;
  logic [AW-1:0] base_addr_in;
  logic [MW-1:0] matrix_width_in;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [WW-1:0] west_ports;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic          cfg_err;

  systolic_wavefront_feeder #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .LANES      (LANES)
  ) dut (
    .clk             (clk),
    .rst_flush       (rst_flush),
    .start           (start),
    .base_addr_in    (base_addr_in),
    .matrix_width_in (matrix_width_in),
    .rd_en           (rd_en),
    .rd_addr         (rd_addr),
    .rd_data         (rd_data),
    .west_ports      (west_ports),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .busy            (busy),
    .done            (done),
    .cfg_err         (cfg_err)
  );

  always #5 clk = ~clk;

  // Operand buffer: 1-cycle read latency.
  logic [DW-1:0] mem [256];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Reference matrix, row-major: amat[r*M + c] = A[r][c].
  logic [DW-1:0] amat [$];
  logic [WW-1:0] got_q [$];
  logic [AW-1:0] addr_q [$];
  int done_cnt = 0, cfg_cnt = 0, busy_cnt = 0, last_rise = 0;
  logic          prev_valid = 1'b0;
  logic          hold_pending = 1'b0;
  logic [WW-1:0] hold_west = '0;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Wavefront k, lane i = A[i][k-i] when that element exists, else 0.
  function automatic logic [WW-1:0] exp_wave(input int k, input int m);
    logic [WW-1:0] w;
    w = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      int c;
      c = k - i;
      if (i < m && c >= 0 && c < m) w[i*DW +: DW] = amat[i*m + c];
    end
    return w;
  endfunction

  // Mid-cycle observer: transfers, reads, pulses, and stability under backpressure.
  always @(negedge clk) begin
    if (hold_pending) begin
      check("hold_valid", WW'(out_valid), WW'(1));
      check("hold_west", west_ports, hold_west);
    end
    hold_pending = out_valid && !out_ready;
    hold_west    = west_ports;
    if (rd_en) addr_q.push_back(rd_addr);
    if (out_valid && out_ready) got_q.push_back(west_ports);
    if (out_valid && !prev_valid) last_rise = edge_cnt;
    prev_valid = out_valid;
    if (done) done_cnt++;
    if (cfg_err) cfg_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic clear_obs();
    got_q.delete();
    addr_q.delete();
    done_cnt = 0;
    cfg_cnt  = 0;
    busy_cnt = 0;
  endtask

  task automatic load_matrix(input int base, input int m, input bit seq);
    amat.delete();
    for (int idx = 0; idx < m * m; idx++) begin
      amat.push_back(seq ? DW'(idx + 1) : DW'($urandom));
      mem[AW'(base + idx)] = amat[idx];
    end
  endtask

  // rmode: 0 = always ready, 1 = random ready + ignored start mid-run,
  //        2 = ready low for 5 cycles once wavefront 2 is presented.
  task automatic run_matrix(input int base, input int m, input bit seq, input int rmode,
                            output int rise_delta);
    int start_edge, cyc, bp;
    load_matrix(base, m, seq);
    clear_obs();
    @(posedge clk); #1;
    start = 1'b1; base_addr_in = AW'(base); matrix_width_in = MW'(m); out_ready = 1'b1;
    start_edge = edge_cnt + 1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; bp = 0;
    while (done_cnt == 0 && cyc < 600) begin
      start = 1'b0;
      case (rmode)
        1: begin
          out_ready = ($urandom_range(0, 3) != 0);
          if (cyc == 4) begin start = 1'b1; matrix_width_in = '0; end
        end
        2: begin
          if (got_q.size() == 2 && out_valid && bp < 5) begin out_ready = 1'b0; bp++; end
          else out_ready = 1'b1;
        end
        default: out_ready = 1'b1;
      endcase
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("done_once", WW'(done_cnt), WW'(1));
    check("wave_count", WW'(got_q.size()), WW'(2 * m - 1));
    for (int k = 0; k < got_q.size() && k < 2 * m - 1; k++)
      check($sformatf("wave%0d_m%0d", k, m), got_q[k], exp_wave(k, m));
    check("read_count", WW'(addr_q.size()), WW'(m * m));
    check("idle_after", WW'(busy), WW'(0));
    check("no_cfg_err", WW'(cfg_cnt), WW'(0));
    rise_delta = last_rise - start_edge;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_rd_en"}, WW'(rd_en), WW'(0));
    check({pfx, "_rd_addr"}, WW'(rd_addr), WW'(0));
    check({pfx, "_west"}, west_ports, WW'(0));
    check({pfx, "_out_valid"}, WW'(out_valid), WW'(0));
    check({pfx, "_busy"}, WW'(busy), WW'(0));
    check({pfx, "_done"}, WW'(done), WW'(0));
    check({pfx, "_cfg_err"}, WW'(cfg_err), WW'(0));
  endtask

  initial begin
    int d;
    logic [WW-1:0] e;
    rst_flush = 1'b1; start = 1'b0; base_addr_in = '0; matrix_width_in = '0;
    out_ready = 1'b1; rd_data = '0;
    for (int a = 0; a < 256; a++) mem[a] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_flush = 1'b0;

    // M=4, base 16, A[r][c] = 4r+c+1.
    run_matrix(16, 4, 1'b1, 0, d);
    check("final_rise_m4", WW'(d), WW'(23));
    if (got_q.size() == 7) begin
      e = {32'd0, 32'd0, 32'd0, 32'd1};
      check("tp_wave0", got_q[0], e);
      e = {32'd13, 32'd10, 32'd7, 32'd4};
      check("tp_wave3", got_q[3], e);
      e = {32'd16, 32'd0, 32'd0, 32'd0};
      check("tp_wave6", got_q[6], e);
    end
    if (addr_q.size() == 16) begin
      check("wf1_addr0", WW'(addr_q[1]), WW'(17));
      check("wf1_addr1", WW'(addr_q[2]), WW'(20));
    end

    // M=2: three wavefronts, lanes 2-3 zero.
    run_matrix(16, 2, 1'b1, 0, d);
    check("final_rise_m2", WW'(d), WW'(7));
    if (got_q.size() == 3) begin
      e = {32'd0, 32'd0, 32'd0, 32'd1};
      check("m2_wave0", got_q[0], e);
      e = {32'd0, 32'd0, 32'd3, 32'd2};
      check("m2_wave1", got_q[1], e);
      e = {32'd0, 32'd0, 32'd4, 32'd0};
      check("m2_wave2", got_q[2], e);
    end

    // Backpressure at wavefront 2.
    run_matrix(16, 4, 1'b1, 2, d);

    // Address wrap.
    run_matrix(250, 4, 1'b1, 0, d);
    check("final_rise_wrap", WW'(d), WW'(23));
    if (addr_q.size() == 16) check("wrap_last_addr", WW'(addr_q[15]), WW'(9));

    // Rejected sizes.
    for (int t = 0; t < 2; t++) begin
      clear_obs();
      @(posedge clk); #1;
      start = 1'b1; matrix_width_in = (t == 0) ? MW'(5) : MW'(0);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check($sformatf("cfg_err_pulse%0d", t), WW'(cfg_cnt), WW'(1));
      check($sformatf("cfg_busy%0d", t), WW'(busy_cnt), WW'(0));
      check($sformatf("cfg_no_read%0d", t), WW'(addr_q.size()), WW'(0));
    end

    // Flush mid-run with a read in flight.
    load_matrix(16, 4, 1'b1);
    @(posedge clk); #1;
    start = 1'b1; base_addr_in = AW'(16); matrix_width_in = MW'(4);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("flush_inflight", WW'(rd_en), WW'(1));
    rst_flush = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("flush");
    rst_flush = 1'b0;
    run_matrix(16, 4, 1'b1, 0, d);
    check("final_rise_postflush", WW'(d), WW'(23));

    // Random sizes, bases, data and backpressure.
    for (int t = 0; t < 6; t++)
      run_matrix(int'($urandom_range(0, 255)), int'($urandom_range(1, 4)), 1'b0, 1, d);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
